fetch_sequencer: RTL

Instruction-fetch front end that feeds the control decoder. It drives the instruction-memory address, aligns the 1-cycle-latency imem read data with the PC of the instruction being executed, and splits the word into opcode/ALU-op/register/immediate fields. It consumes the decoder's redirect outcome (branch taken, j/jal, jr) and the multdiv stall request, squashing wrong-path fetches and holding the current instruction while stalled.

---
 rtl/fetch_sequencer_if.sv | 35 +++
 rtl/fetch_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// Instruction-fetch bus between the fetch sequencer, instruction memory and decoder.
// master = fetch sequencer side, slave = memory/decoder environment.
interface fetch_sequencer_if;
    logic [31:0] imem_q;
    logic        stall_req;
    logic        br_taken;
    logic        jump;
    logic        jr;
    logic [31:0] jr_target;
    logic [11:0] address_imem;
    logic [31:0] instr;
    logic        instr_valid;
    logic [11:0] exec_pc;
    logic [11:0] pc_plus1;
    logic [4:0]  opcode;
    logic [4:0]  aluop;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [31:0] imm_sext;
    logic [26:0] target;

    modport master (
        input  imem_q, stall_req, br_taken, jump, jr, jr_target,
        output address_imem, instr, instr_valid, exec_pc, pc_plus1,
               opcode, aluop, rd, rs, rt, shamt, imm_sext, target
    );

    modport slave (
        output imem_q, stall_req, br_taken, jump, jr, jr_target,
        input  address_imem, instr, instr_valid, exec_pc, pc_plus1,
               opcode, aluop, rd, rs, rt, shamt, imm_sext, target
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: drives imem address, aligns 1-cycle imem data with
// the executing PC, squashes wrong-path fetches on redirect and holds on stall.
module fetch_sequencer (
    input  logic              clock,
    input  logic              reset,
    fetch_sequencer_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, SQUASH, STALL} state_t;

    state_t      state, state_n;
    logic [11:0] fetch_pc, fetch_pc_n;
    logic [11:0] exec_pc, exec_pc_n;
    logic [31:0] hold, hold_n;
    logic [31:0] cur_instr;
    logic        cur_valid;
    logic signed [31:0] imm_ext;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic        unused_bits;

    function automatic logic [11:0] pc_add(input logic [11:0] a, input logic [11:0] b);
        return a + b;
    endfunction

    // The instruction being executed: live imem data in RUN, the captured word while stalled.
    always_comb begin
        cur_instr = '0;
        cur_valid = 1'b0;
        case (state)
            RUN: begin
                cur_instr = bus.imem_q;
                cur_valid = 1'b1;
            end
            STALL: begin
                cur_instr = hold;
                cur_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign imm_ext  = {{15{cur_instr[16]}}, cur_instr[16:0]};
    assign redirect = bus.jr | bus.jump | bus.br_taken;

    always_comb begin
        if (bus.jr)
            redirect_pc = bus.jr_target[11:0];
        else if (bus.jump)
            redirect_pc = cur_instr[11:0];
        else
            redirect_pc = pc_add(pc_add(exec_pc, 12'd1), imm_ext[11:0]);
    end

    // Only the low 12 bits of a jr target address the 4096-word imem.
    assign unused_bits = ^bus.jr_target[31:12];

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        exec_pc_n  = exec_pc;
        hold_n     = hold;
        case (state)
            BOOT: begin
                exec_pc_n  = 12'd0;
                fetch_pc_n = 12'd1;
                state_n    = RUN;
            end
            RUN, STALL: begin
                if (bus.stall_req) begin
                    if (state == RUN)
                        hold_n = bus.imem_q;
                    state_n = STALL;
                end else if (redirect) begin
                    fetch_pc_n = redirect_pc;
                    state_n    = SQUASH;
                end else begin
                    exec_pc_n  = fetch_pc;
                    fetch_pc_n = pc_add(fetch_pc, 12'd1);
                    state_n    = RUN;
                end
            end
            SQUASH: begin
                exec_pc_n  = fetch_pc;
                fetch_pc_n = pc_add(fetch_pc, 12'd1);
                state_n    = RUN;
            end
            default: state_n = BOOT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            fetch_pc <= '0;
            exec_pc  <= '0;
            hold     <= '0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            exec_pc  <= exec_pc_n;
            hold     <= hold_n;
        end
    end

    assign bus.address_imem = fetch_pc;
    assign bus.instr        = cur_instr;
    assign bus.instr_valid  = cur_valid;
    assign bus.exec_pc      = exec_pc;
    assign bus.pc_plus1     = pc_add(exec_pc, 12'd1);
    assign bus.opcode       = cur_instr[31:27];
    assign bus.aluop        = cur_instr[6:2];
    assign bus.rd           = cur_instr[26:22];
    assign bus.rs           = cur_instr[21:17];
    assign bus.rt           = cur_instr[16:12];
    assign bus.shamt        = cur_instr[11:7];
    assign bus.imm_sext     = imm_ext;
    assign bus.target       = cur_instr[26:0];
endmodule
